// File: rtl/axi4lite_stream_fifo_pkg.sv
// -----------------------------------------------------------------------------
// axi4lite_stream_fifo_pkg
// Shared definitions for the AXI4-Lite stream FIFO bank: register offsets,
// bit positions inside STATUS/CTRL/CLR, AXI response codes and the address
// decoder used by both the read and the write path.
// -----------------------------------------------------------------------------
package axi4lite_stream_fifo_pkg;

    // Register offsets (byte addresses on the 6-bit AXI address bus)
    localparam logic [5:0] ADDR_DATA0  = 6'h00;  // DATA_ch at ADDR_DATA0 + 4*ch
    localparam logic [5:0] ADDR_STATUS = 6'h20;
    localparam logic [5:0] ADDR_CTRL   = 6'h24;
    localparam logic [5:0] ADDR_CLR    = 6'h28;
    localparam logic [5:0] ADDR_THRESH = 6'h2C;  // only mapped with AXI4L_FIFO_IRQ_EN

    // Bit positions (channel ch adds ch to the LSB)
    localparam int STATUS_NEMPTY_LSB = 0;
    localparam int STATUS_OVF_LSB    = 8;
    localparam int CTRL_EN_LSB       = 0;
    localparam int CLR_FLUSH_LSB     = 0;
    localparam int CLR_OVF_LSB       = 8;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        SEL_DATA,
        SEL_STATUS,
        SEL_CTRL,
        SEL_CLR,
        SEL_THRESH,
        SEL_NONE
    } reg_sel_e;

    // Word-aligned decode; misaligned addresses fall into SEL_NONE.
    function automatic reg_sel_e decode_reg(input logic [5:0] addr);
        reg_sel_e sel;
        sel = SEL_NONE;
        if (addr[1:0] == 2'b00) begin
            if (addr < ADDR_STATUS) begin
                sel = SEL_DATA;
            end else begin
                case (addr)
                    ADDR_STATUS: sel = SEL_STATUS;
                    ADDR_CTRL:   sel = SEL_CTRL;
                    ADDR_CLR:    sel = SEL_CLR;
                    ADDR_THRESH: sel = SEL_THRESH;
                    default:     sel = SEL_NONE;
                endcase
            end
        end
        return sel;
    endfunction

    // Channel index addressed by a DATA_ch access (0..7).
    function automatic logic [2:0] data_ch(input logic [5:0] addr);
        logic [5:0] off;
        off = addr - ADDR_DATA0;
        return off[4:2];
    endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// -----------------------------------------------------------------------------
// axis_sync_fifo
// Single-clock FIFO holding DEPTH samples of WIDTH bits, with flush.
//   clk, rst    : clock, synchronous active-high reset (FIFO empty)
//   push        : write push_data (ignored when full unless popping, or on flush)
//   push_data   : sample to write
//   pop         : remove the head sample (ignored when empty)
//   flush       : empty the FIFO; wins over a same-cycle push
//   head        : current head sample, valid while !empty
//   full, empty : status flags
//   level       : number of stored samples (0..DEPTH)
// -----------------------------------------------------------------------------
module axis_sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_reg == (AW+1)'(DEPTH));
    assign empty = (count_reg == '0);
    assign level = count_reg;
    // Head is read asynchronously so the register block can capture it in
    // the same cycle as the pop is decided.
    assign head  = mem[rd_ptr_reg];

    assign do_pop  = pop & ~empty;
    // A full FIFO still takes a sample when a pop frees a slot this cycle.
    assign do_push = push & (~full | do_pop) & ~flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= push_data;
    end

endmodule

// File: rtl/axi4lite_stream_fifo_bank.sv
// -----------------------------------------------------------------------------
// axi4lite_stream_fifo_bank
// NCH AXI-Stream sample inputs, each buffered in its own FIFO and drained
// by AXI4-Lite reads of DATA_ch (one read pops one sample, sign-extended).
//   clk, rst            : clock, synchronous active-high reset
//   s_axi_aw*/w*/b*     : AXI4-Lite write channel (CTRL, CLR, THRESH)
//   s_axi_ar*/r*        : AXI4-Lite read channel (DATA_ch, STATUS, CTRL, THRESH)
//   s_axis_tdata/tvalid/tready : per-channel sample inputs, ch at
//                         tdata[ch*AXIS_DW +: AXIS_DW]
//   irq                 : level interrupt, only with AXI4L_FIFO_IRQ_EN
// Build option: define AXI4L_FIFO_IRQ_EN to add the THRESH register and irq.
// AXI_DW must be at least 8+NCH so STATUS/CLR overflow bits fit.
// -----------------------------------------------------------------------------
module axi4lite_stream_fifo_bank
    import axi4lite_stream_fifo_pkg::*;
#(
    parameter int AXI_DW       = 32,
    parameter int AXIS_DW      = 24,
    parameter int NCH          = 4,
    parameter int DEPTH        = 16,
    parameter int DROP_ON_FULL = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [5:0]             s_axi_awaddr,
    input  logic [2:0]             s_axi_awprot,
    input  logic                   s_axi_awvalid,
    output logic                   s_axi_awready,
    input  logic [AXI_DW-1:0]      s_axi_wdata,
    input  logic [3:0]             s_axi_wstrb,
    input  logic                   s_axi_wvalid,
    output logic                   s_axi_wready,
    output logic [1:0]             s_axi_bresp,
    output logic                   s_axi_bvalid,
    input  logic                   s_axi_bready,
    input  logic [5:0]             s_axi_araddr,
    input  logic [2:0]             s_axi_arprot,
    input  logic                   s_axi_arvalid,
    output logic                   s_axi_arready,
    output logic [AXI_DW-1:0]      s_axi_rdata,
    output logic [1:0]             s_axi_rresp,
    output logic                   s_axi_rvalid,
    input  logic                   s_axi_rready,
    input  logic [NCH*AXIS_DW-1:0] s_axis_tdata,
    input  logic [NCH-1:0]         s_axis_tvalid,
    output logic [NCH-1:0]         s_axis_tready
`ifdef AXI4L_FIFO_IRQ_EN
    ,
    output logic                   irq
`endif
);

    localparam int LW = $clog2(DEPTH) + 1;

    logic [NCH-1:0]     ctrl_reg;
    logic [NCH-1:0]     ovf_reg;
    logic [NCH-1:0]     full_vec, empty_vec, push_fire, pop_vec;
    logic [NCH-1:0]     flush_vec, clr_ovf_vec, ovf_set_vec;
    logic [AXIS_DW-1:0] head_arr  [NCH];
    logic [LW-1:0]      level_arr [NCH];

    logic               bvalid_reg, rvalid_reg;
    logic [1:0]         bresp_reg, rresp_reg;
    logic [AXI_DW-1:0]  rdata_reg;

    logic               wr_fire, rd_fire, wr_ok, ctrl_we;
    reg_sel_e           wr_sel, rd_sel;
    logic [2:0]         rd_ch;
    logic [AXIS_DW-1:0] head_sel;
    logic               empty_sel;
    logic [AXI_DW-1:0]  status_word, rd_data_next;
    logic [1:0]         rd_resp_next;

`ifdef AXI4L_FIFO_IRQ_EN
    logic [LW-1:0]      thresh_reg;
    logic               thresh_we;
    logic               irq_reg, irq_next;
`endif

    // Protection/strobe are ignored; wdata is only partly used.
    logic unused_inputs;
    assign unused_inputs = ^{s_axi_awprot, s_axi_arprot, s_axi_wstrb, s_axi_wdata};

    // ------------------------------------------------------------ stream side
    assign s_axis_tready = (DROP_ON_FULL != 0) ? ctrl_reg : (ctrl_reg & ~full_vec);
    assign push_fire     = s_axis_tvalid & s_axis_tready;
    // Only reachable in drop mode: a push that finds the FIFO full and no
    // pop/flush to absorb it is lost and flagged.
    assign ovf_set_vec   = push_fire & full_vec & ~pop_vec & ~flush_vec;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        axis_sync_fifo #(
            .WIDTH (AXIS_DW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (push_fire[gi]),
            .push_data (s_axis_tdata[gi*AXIS_DW +: AXIS_DW]),
            .pop       (pop_vec[gi]),
            .flush     (flush_vec[gi]),
            .head      (head_arr[gi]),
            .full      (full_vec[gi]),
            .empty     (empty_vec[gi]),
            .level     (level_arr[gi])
        );
`ifndef AXI4L_FIFO_IRQ_EN
        logic unused_level;
        assign unused_level = ^level_arr[gi];
`endif
    end

    // ------------------------------------------------------------ write path
    assign wr_fire       = s_axi_awvalid & s_axi_wvalid & ~bvalid_reg;
    assign s_axi_awready = wr_fire;
    assign s_axi_wready  = wr_fire;
    assign wr_sel        = decode_reg(s_axi_awaddr);

    always_comb begin
        wr_ok       = 1'b0;
        ctrl_we     = 1'b0;
        flush_vec   = '0;
        clr_ovf_vec = '0;
`ifdef AXI4L_FIFO_IRQ_EN
        thresh_we   = 1'b0;
`endif
        case (wr_sel)
            SEL_CTRL: begin
                wr_ok   = 1'b1;
                ctrl_we = wr_fire;
            end
            SEL_CLR: begin
                // Self-clearing: CLR only acts during the write handshake.
                wr_ok = 1'b1;
                if (wr_fire) begin
                    flush_vec   = s_axi_wdata[CLR_FLUSH_LSB +: NCH];
                    clr_ovf_vec = s_axi_wdata[CLR_OVF_LSB +: NCH];
                end
            end
`ifdef AXI4L_FIFO_IRQ_EN
            SEL_THRESH: begin
                wr_ok     = 1'b1;
                thresh_we = wr_fire;
            end
`endif
            default: ;
        endcase
    end

    // ------------------------------------------------------------ read path
    assign rd_fire       = s_axi_arvalid & ~rvalid_reg;
    assign s_axi_arready = ~rvalid_reg;
    assign rd_sel        = decode_reg(s_axi_araddr);
    assign rd_ch         = data_ch(s_axi_araddr);

    always_comb begin
        pop_vec      = '0;
        head_sel     = '0;
        empty_sel    = 1'b1;  // channels >= NCH look permanently empty
        status_word  = '0;
        rd_data_next = '0;
        rd_resp_next = RESP_SLVERR;
        for (int c = 0; c < NCH; c++) begin
            status_word[STATUS_NEMPTY_LSB + c] = ~empty_vec[c];
            status_word[STATUS_OVF_LSB + c]    = ovf_reg[c];
            if (rd_ch == 3'(c)) begin
                head_sel  = head_arr[c];
                empty_sel = empty_vec[c];
            end
        end
        case (rd_sel)
            SEL_DATA: begin
                if (!empty_sel) begin
                    rd_data_next = AXI_DW'($signed(head_sel));
                    rd_resp_next = RESP_OKAY;
                    for (int c = 0; c < NCH; c++) begin
                        pop_vec[c] = rd_fire & (rd_ch == 3'(c));
                    end
                end
            end
            SEL_STATUS: begin
                rd_data_next = status_word;
                rd_resp_next = RESP_OKAY;
            end
            SEL_CTRL: begin
                rd_data_next = AXI_DW'(ctrl_reg);
                rd_resp_next = RESP_OKAY;
            end
            SEL_CLR: begin
                rd_resp_next = RESP_OKAY;  // write-only, reads as zero
            end
`ifdef AXI4L_FIFO_IRQ_EN
            SEL_THRESH: begin
                rd_data_next = AXI_DW'(thresh_reg);
                rd_resp_next = RESP_OKAY;
            end
`endif
            default: ;
        endcase
    end

    // ------------------------------------------------------------ registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_reg   <= '0;
            ovf_reg    <= '0;
            bvalid_reg <= 1'b0;
            bresp_reg  <= RESP_OKAY;
            rvalid_reg <= 1'b0;
            rresp_reg  <= RESP_OKAY;
            rdata_reg  <= '0;
        end else begin
            if (ctrl_we) ctrl_reg <= s_axi_wdata[CTRL_EN_LSB +: NCH];
            // Clear wins over a same-cycle set.
            ovf_reg <= (ovf_reg | ovf_set_vec) & ~clr_ovf_vec;

            if (wr_fire) begin
                bvalid_reg <= 1'b1;
                bresp_reg  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (s_axi_bready) begin
                bvalid_reg <= 1'b0;
            end

            if (rd_fire) begin
                rvalid_reg <= 1'b1;
                rdata_reg  <= rd_data_next;
                rresp_reg  <= rd_resp_next;
            end else if (s_axi_rready) begin
                rvalid_reg <= 1'b0;
            end
        end
    end

    assign s_axi_bvalid = bvalid_reg;
    assign s_axi_bresp  = bresp_reg;
    assign s_axi_rvalid = rvalid_reg;
    assign s_axi_rresp  = rresp_reg;
    assign s_axi_rdata  = rdata_reg;

`ifdef AXI4L_FIFO_IRQ_EN
    always_comb begin
        irq_next = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            if (ctrl_reg[c] && (level_arr[c] >= thresh_reg)) irq_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            thresh_reg <= LW'(DEPTH / 2);
            irq_reg    <= 1'b0;
        end else begin
            if (thresh_we) thresh_reg <= s_axi_wdata[LW-1:0];
            irq_reg <= irq_next;
        end
    end

    assign irq = irq_reg;
`endif

endmodule

// File: tb/tb_axi4lite_stream_fifo_bank.sv
// Directed bench: instance 0 uses backpressure, instance 1 drops on full.
module tb_axi4lite_stream_fifo_bank;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [5:0]  awaddr [2];
    logic [5:0]  araddr [2];
    logic        awvalid[2], wvalid[2], bready[2], arvalid[2], rready[2];
    logic [31:0] wdata  [2];
    logic [95:0] tdata  [2];
    logic [3:0]  tvalid [2];
    logic        awready[2], wready[2], bvalid[2], arready[2], rvalid[2];
    logic [1:0]  bresp  [2], rresp[2];
    logic [31:0] rdata  [2];
    logic [3:0]  tready [2];
`ifdef AXI4L_FIFO_IRQ_EN
    logic        irq    [2];
`endif
    logic [2:0]  prot_zero = 3'b000;
    logic [3:0]  strb_ones = 4'hF;

    int total = 0;
    int bad   = 0;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        axi4lite_stream_fifo_bank #(
            .AXI_DW(32), .AXIS_DW(24), .NCH(4), .DEPTH(16), .DROP_ON_FULL(gi)
        ) u_dut (
            .clk           (clk),
            .rst           (rst),
            .s_axi_awaddr  (awaddr[gi]),
            .s_axi_awprot  (prot_zero),
            .s_axi_awvalid (awvalid[gi]),
            .s_axi_awready (awready[gi]),
            .s_axi_wdata   (wdata[gi]),
            .s_axi_wstrb   (strb_ones),
            .s_axi_wvalid  (wvalid[gi]),
            .s_axi_wready  (wready[gi]),
            .s_axi_bresp   (bresp[gi]),
            .s_axi_bvalid  (bvalid[gi]),
            .s_axi_bready  (bready[gi]),
            .s_axi_araddr  (araddr[gi]),
            .s_axi_arprot  (prot_zero),
            .s_axi_arvalid (arvalid[gi]),
            .s_axi_arready (arready[gi]),
            .s_axi_rdata   (rdata[gi]),
            .s_axi_rresp   (rresp[gi]),
            .s_axi_rvalid  (rvalid[gi]),
            .s_axi_rready  (rready[gi]),
            .s_axis_tdata  (tdata[gi]),
            .s_axis_tvalid (tvalid[gi]),
            .s_axis_tready (tready[gi])
`ifdef AXI4L_FIFO_IRQ_EN
            ,
            .irq           (irq[gi])
`endif
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic axi_write(input int d, input logic [5:0] a, input logic [31:0] v,
                             output logic [1:0] resp);
        int n;
        awaddr[d] = a; wdata[d] = v; awvalid[d] = 1'b1; wvalid[d] = 1'b1;
        #1;
        n = 0;
        while (!awready[d] && n < 16) begin @(negedge clk); n++; end
        check("aw_handshake", 32'(awready[d]), 32'd1);
        @(negedge clk);
        awvalid[d] = 1'b0; wvalid[d] = 1'b0;
        n = 0;
        while (!bvalid[d] && n < 16) begin @(negedge clk); n++; end
        check("b_valid", 32'(bvalid[d]), 32'd1);
        resp = bresp[d];
        bready[d] = 1'b1;
        @(negedge clk);
        bready[d] = 1'b0;
        $display("wr dut%0d addr=0x%02h data=0x%08h resp=%0d", d, a, v, resp);
    endtask

    task automatic axi_read(input int d, input logic [5:0] a,
                            output logic [31:0] data, output logic [1:0] resp);
        int n;
        araddr[d] = a; arvalid[d] = 1'b1;
        #1;
        n = 0;
        while (!arready[d] && n < 16) begin @(negedge clk); n++; end
        check("ar_handshake", 32'(arready[d]), 32'd1);
        @(negedge clk);
        arvalid[d] = 1'b0;
        n = 0;
        while (!rvalid[d] && n < 16) begin @(negedge clk); n++; end
        check("r_valid", 32'(rvalid[d]), 32'd1);
        data = rdata[d]; resp = rresp[d];
        rready[d] = 1'b1;
        @(negedge clk);
        rready[d] = 1'b0;
        $display("rd dut%0d addr=0x%02h data=0x%08h resp=%0d", d, a, data, resp);
    endtask

    task automatic wr_expect(input string tag, input int d, input logic [5:0] a,
                             input logic [31:0] v, input logic [1:0] exp_resp);
        logic [1:0] r;
        axi_write(d, a, v, r);
        check(tag, 32'(r), 32'(exp_resp));
    endtask

    task automatic rd_expect(input string tag, input int d, input logic [5:0] a,
                             input logic [31:0] exp_data, input logic [1:0] exp_resp);
        logic [31:0] v;
        logic [1:0]  r;
        axi_read(d, a, v, r);
        check({tag, "_data"}, v, exp_data);
        check({tag, "_resp"}, 32'(r), 32'(exp_resp));
    endtask

    task automatic push(input int d, input int ch, input logic [23:0] v);
        int n;
        tdata[d][ch*24 +: 24] = v;
        tvalid[d][ch] = 1'b1;
        #1;
        n = 0;
        while (!tready[d][ch] && n < 16) begin @(negedge clk); n++; end
        check("push_ready", 32'(tready[d][ch]), 32'd1);
        @(negedge clk);
        tvalid[d][ch] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            awaddr[d] = '0; araddr[d] = '0; wdata[d] = '0; tdata[d] = '0; tvalid[d] = '0;
            awvalid[d] = 1'b0; wvalid[d] = 1'b0; bready[d] = 1'b0;
            arvalid[d] = 1'b0; rready[d] = 1'b0;
        end
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // Reset state
        for (int d = 0; d < 2; d++) begin
            check("rst_tready", 32'(tready[d]), 32'd0);
            check("rst_rvalid", 32'(rvalid[d]), 32'd0);
            check("rst_bvalid", 32'(bvalid[d]), 32'd0);
            check("rst_rdata",  rdata[d], 32'd0);
            check("rst_rresp",  32'(rresp[d]), 32'd0);
            check("rst_bresp",  32'(bresp[d]), 32'd0);
`ifdef AXI4L_FIFO_IRQ_EN
            check("rst_irq",    32'(irq[d]), 32'd0);
`endif
        end
        rst = 1'b0;
        @(negedge clk);
        rd_expect("rst_status", 0, 6'h20, 32'h0, 2'b00);
        rd_expect("rst_ctrl",   1, 6'h24, 32'h0, 2'b00);

        // Sign-extended pops on ch0, then an empty read
        wr_expect("ctrl_wr", 0, 6'h24, 32'h1, 2'b00);
        check("ctrl_tready", 32'(tready[0]), 32'h1);
        push(0, 0, 24'h800001);
        push(0, 0, 24'h000002);
        push(0, 0, 24'h7FFFFF);
        rd_expect("sx_neg",   0, 6'h00, 32'hFF800001, 2'b00);
        rd_expect("sx_small", 0, 6'h00, 32'h00000002, 2'b00);
        rd_expect("sx_pos",   0, 6'h00, 32'h007FFFFF, 2'b00);
        rd_expect("empty_rd", 0, 6'h00, 32'h0, 2'b10);

        // Backpressure: 20 beats into ch1 of a 16-deep FIFO
        wr_expect("ctrl_ch1", 0, 6'h24, 32'h2, 2'b00);
        for (int i = 0; i < 16; i++) push(0, 1, 24'(32'h10 + i));
        check("bp_tready_full", 32'(tready[0][1]), 32'd0);
        tdata[0][24 +: 24] = 24'h20;
        tvalid[0][1] = 1'b1;
        repeat (3) @(negedge clk);
        check("bp_tready_held", 32'(tready[0][1]), 32'd0);
        tvalid[0][1] = 1'b0;
        rd_expect("bp_status", 0, 6'h20, 32'h00000002, 2'b00);
        for (int i = 0; i < 16; i++) rd_expect("bp_data", 0, 6'h04, 32'h10 + i, 2'b00);
        for (int i = 0; i < 4; i++) push(0, 1, 24'(32'h20 + i));
        for (int i = 0; i < 4; i++) rd_expect("bp_tail", 0, 6'h04, 32'h20 + i, 2'b00);
        rd_expect("bp_empty", 0, 6'h04, 32'h0, 2'b10);

        // Register map edges
        rd_expect("ctrl_rd",     0, 6'h24, 32'h2, 2'b00);
        rd_expect("data4_rd",    0, 6'h10, 32'h0, 2'b10);
        rd_expect("misalign_rd", 0, 6'h21, 32'h0, 2'b10);
        wr_expect("status_wr",   0, 6'h20, 32'h1, 2'b10);
        wr_expect("data_wr",     0, 6'h00, 32'h1, 2'b10);
`ifdef AXI4L_FIFO_IRQ_EN
        rd_expect("thresh_rst",  0, 6'h2C, 32'h8, 2'b00);
`else
        rd_expect("thresh_unmapped_rd", 0, 6'h2C, 32'h0, 2'b10);
        wr_expect("thresh_unmapped_wr", 0, 6'h2C, 32'h4, 2'b10);
`endif

        // Drop mode: 17 pushes on ch0, overflow flag and clear
        wr_expect("drop_ctrl", 1, 6'h24, 32'hD, 2'b00);
        for (int i = 0; i < 17; i++) push(1, 0, 24'(32'h100 + i));
        rd_expect("ovf_status", 1, 6'h20, 32'h00000101, 2'b00);
        for (int i = 0; i < 16; i++) rd_expect("ovf_data", 1, 6'h00, 32'h100 + i, 2'b00);
        rd_expect("ovf_17th_absent", 1, 6'h00, 32'h0, 2'b10);
        rd_expect("ovf_still_set", 1, 6'h20, 32'h00000100, 2'b00);
        wr_expect("clr_ovf_wr", 1, 6'h28, 32'h100, 2'b00);
        rd_expect("ovf_cleared", 1, 6'h20, 32'h0, 2'b00);

        // Full ch2: push and pop in the same cycle
        for (int i = 0; i < 16; i++) push(1, 2, 24'(32'h200 + i));
        tdata[1][48 +: 24] = 24'h210;
        tvalid[1][2] = 1'b1;
        araddr[1] = 6'h08;
        arvalid[1] = 1'b1;
        #1;
        check("pp_arready", 32'(arready[1]), 32'd1);
        check("pp_tready",  32'(tready[1][2]), 32'd1);
        @(negedge clk);
        tvalid[1][2] = 1'b0;
        arvalid[1] = 1'b0;
        check("pp_rvalid", 32'(rvalid[1]), 32'd1);
        check("pp_rdata",  rdata[1], 32'h200);
        check("pp_rresp",  32'(rresp[1]), 32'd0);
        rready[1] = 1'b1;
        @(negedge clk);
        rready[1] = 1'b0;
        rd_expect("pp_status", 1, 6'h20, 32'h00000004, 2'b00);
        for (int i = 0; i < 16; i++) rd_expect("pp_data", 1, 6'h08, 32'h201 + i, 2'b00);
        rd_expect("pp_level16", 1, 6'h08, 32'h0, 2'b10);

        // Full ch3: flush coincident with a push that would otherwise overflow
        for (int i = 0; i < 16; i++) push(1, 3, 24'(32'h300 + i));
        awaddr[1] = 6'h28; wdata[1] = 32'h8; awvalid[1] = 1'b1; wvalid[1] = 1'b1;
        tdata[1][72 +: 24] = 24'h3FF;
        tvalid[1][3] = 1'b1;
        #1;
        check("fl_awready", 32'(awready[1]), 32'd1);
        @(negedge clk);
        awvalid[1] = 1'b0; wvalid[1] = 1'b0; tvalid[1][3] = 1'b0;
        check("fl_bvalid", 32'(bvalid[1]), 32'd1);
        check("fl_bresp",  32'(bresp[1]), 32'd0);
        bready[1] = 1'b1;
        @(negedge clk);
        bready[1] = 1'b0;
        rd_expect("fl_status", 1, 6'h20, 32'h0, 2'b00);
        rd_expect("fl_empty",  1, 6'h0C, 32'h0, 2'b10);
        push(1, 3, 24'hABCDEF);
        rd_expect("fl_after", 1, 6'h0C, 32'hFFABCDEF, 2'b00);

`ifdef AXI4L_FIFO_IRQ_EN
        // Threshold interrupt on ch0 of instance 0
        wr_expect("irq_ctrl",   0, 6'h24, 32'h1, 2'b00);
        wr_expect("irq_thresh", 0, 6'h2C, 32'h4, 2'b00);
        for (int i = 0; i < 3; i++) push(0, 0, 24'(32'h40 + i));
        check("irq_below", 32'(irq[0]), 32'd0);
        push(0, 0, 24'h43);
        check("irq_same_cycle", 32'(irq[0]), 32'd0);
        @(negedge clk);
        check("irq_high", 32'(irq[0]), 32'd1);
        rd_expect("irq_pop", 0, 6'h00, 32'h40, 2'b00);
        check("irq_low", 32'(irq[0]), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi4lite_stream_fifo_bank.md
AXI4LITE_STREAM_FIFO_BANK -- requirements
Module: axi4lite_stream_fifo_bank

Interface
REQ-001 SHALL have parameter AXI_DW, default 32, AXI data width.
REQ-002 SHALL have parameter AXIS_DW, default 24, stream sample width; legal range 1..AXI_DW.
REQ-003 SHALL have parameter NCH, default 4, stream channel count; legal range 1..8.
REQ-004 SHALL have parameter DEPTH, default 16, per-channel FIFO depth; power of 2, minimum 2.
REQ-005 SHALL have parameter DROP_ON_FULL, default 0: 0 means backpressure; 1 means drop and flag.
REQ-006 SHALL use one clock; reset is synchronous and active-high.
REQ-007 SHALL have ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_axi_aw{addr[6],prot[3],valid,ready}, s_axi_w{data[AXI_DW],strb[4],valid,ready}, s_axi_b{resp[2],valid,ready}: AXI4-Lite write
- s_axi_ar{addr[6],prot[3],valid,ready}, s_axi_r{data[AXI_DW],resp[2],valid,ready}: AXI4-Lite read
- s_axis_tdata  in  NCH*AXIS_DW  channel ch occupies bits [ch*AXIS_DW +: AXIS_DW]
- s_axis_tvalid  in  NCH  per-channel valid
- s_axis_tready  out  NCH  per-channel ready
- irq  out  1  level interrupt; present only with AXI4L_FIFO_IRQ_EN

Function
REQ-008 SHALL decode a register map; prot and strb are ignored:
- 0x00+4*ch DATA_ch (RO): read pops channel ch.
- 0x20 STATUS (RO): bit ch = non-empty; bit 8+ch = sticky overflow.
- 0x24 CTRL (RW): bit ch = channel enable.
- 0x28 CLR (WO, self-clearing): bit ch = flush FIFO; bit 8+ch = clear overflow.
REQ-009 SHALL hold DEPTH samples per channel in its FIFO; full = DEPTH entries; pointers wrap modulo DEPTH.
REQ-010 SHALL drive s_axis_tready[ch] = CTRL[ch] & !full[ch] when DROP_ON_FULL=0, and = CTRL[ch] when DROP_ON_FULL=1.
REQ-011 SHALL push on tvalid&tready; with DROP_ON_FULL=1 a push while full with no pop that cycle is discarded and sets overflow[ch].
REQ-012 SHALL accept a push while full when a pop of the same channel happens in the same cycle; level is unchanged.
REQ-013 SHALL drive arready = !rvalid, and assert rvalid the cycle after the AR handshake, held until rready.
REQ-014 SHALL register rdata with the head sample sign-extended to AXI_DW; the pop happens at the AR handshake.
REQ-015 SHALL answer a DATA_ch read of an empty channel, or of an unmapped address (including ch>=NCH), with rdata=0 and rresp=SLVERR (2'b10), and no pop.
REQ-016 SHALL drive awready = wready = awvalid & wvalid & !bvalid, and assert bvalid the next cycle, held until bready.
REQ-017 SHALL give bresp OKAY for 0x24/0x28 and SLVERR otherwise.
REQ-018 SHALL give flush priority over a same-cycle push (sample dropped, no overflow set).
REQ-019 SHALL, when a flush and a pop coincide, return the pre-flush head and leave the FIFO empty.
REQ-020 SHALL give clear-overflow priority over a same-cycle overflow set.

Reset
REQ-021 SHALL on rst clear: FIFO pointers (all empty), CTRL=0, overflow=0, rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0, irq=0; s_axis_tready=0 follows from CTRL=0.
REQ-022 SHALL discard a read or write in flight when rst is asserted mid-transaction, with no response issued.

Configuration
REQ-023 SHALL, with AXI4L_FIFO_IRQ_EN defined, add 0x2C THRESH (RW, log2(DEPTH)+1 bits, reset DEPTH/2) and the irq port.
REQ-024 SHALL register irq = OR over ch of (CTRL[ch] & level[ch] >= THRESH), giving 1 cycle latency.
REQ-025 SHALL, without AXI4L_FIFO_IRQ_EN, omit the irq port and treat 0x2C as unmapped (SLVERR).

Structure
REQ-026 SHALL place register offsets, CTRL/CLR/STATUS bit positions and the RESP_OKAY/RESP_SLVERR constants in package axi4lite_stream_fifo_pkg.
REQ-027 SHALL instantiate sub-module axis_sync_fifo (WIDTH, DEPTH; push/pop/flush/full/empty/level) once per channel using generate.

Verification
REQ-028 SHALL cover: CTRL=0x1, push 3 samples 0x800001, 0x000002, 0x7FFFFF on ch0 -> three DATA_0 reads return 0xFF800001, 0x00000002, 0x007FFFFF with OKAY; the fourth read returns 0 with SLVERR.
REQ-029 SHALL cover: DROP_ON_FULL=0, DEPTH=16, ch1 enabled, 20 valid beats -> tready[1] low after 16 pushes, STATUS bit 9 = 0, no data lost after reads.
REQ-030 SHALL cover: DROP_ON_FULL=1, 17 pushes -> STATUS bit 8+ch set, the 17th sample absent; writing CLR=0x100<<ch clears the bit.
REQ-031 SHALL cover: full FIFO with push and DATA read in the same cycle -> push accepted, no overflow, level stays 16.
REQ-032 SHALL cover: CLR flush coincident with a push -> STATUS non-empty bit = 0 next cycle, overflow = 0.
REQ-033 SHALL cover: with AXI4L_FIFO_IRQ_EN, THRESH=4, 4 pushes -> irq high one cycle after the 4th push, low after one read; without the macro, a read of 0x2C -> SLVERR.
